// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole round scheduler:
// state encoding, mole geometry and the mole-selection function.
package mole_pkg;

  localparam int NUM_MOLES  = 4;
  localparam int MOLE_IDX_W = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GAP     = 3'd1,
    UP      = 3'd2,
    RESOLVE = 3'd3,
    OVER    = 3'd4
  } state_t;

  // Never show the same mole twice in a row: bump to the next hole (mod 4).
  function automatic logic [MOLE_IDX_W-1:0] pick_mole(input logic [MOLE_IDX_W-1:0] rnd,
                                                      input logic [MOLE_IDX_W-1:0] last);
    if (rnd == last) begin
      return rnd + 2'd1;
    end else begin
      return rnd;
    end
  endfunction

  function automatic logic [NUM_MOLES-1:0] mole_onehot(input logic [MOLE_IDX_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mole_round_scheduler_if.sv
// Game-side bundle of the round scheduler: start/RNG/buttons in,
// mole display, score and round/game status out.
interface mole_round_scheduler_if
  import mole_pkg::*;
#(
  parameter int SCORE_W = 8
);

  logic                  start;
  logic [MOLE_IDX_W-1:0] rnd;
  logic [NUM_MOLES-1:0]  hit_btn;
  logic [NUM_MOLES-1:0]  mole_on;
  logic [SCORE_W-1:0]    score;
  logic                  round_done;
  logic                  round_hit;
  logic                  game_over;
  logic                  busy;

  modport master (
    output start, rnd, hit_btn,
    input  mole_on, score, round_done, round_hit, game_over, busy
  );

  modport slave (
    input  start, rnd, hit_btn,
    output mole_on, score, round_done, round_hit, game_over, busy
  );

endinterface

// File: rtl/tick_counter.sv
// 32-bit loadable down-counter shared by the GAP and UP intervals;
// parks at zero and flags it.
module tick_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        en,
  output logic        zero
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Load has priority over counting; the count never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != 32'd0)) begin
      cnt_d = cnt_q - 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 32'd0);

endmodule

// File: rtl/mole_round_scheduler.sv
// Whack-a-mole round sequencer: gap, pick a mole, score hit/miss, repeat ROUNDS times.
// Optional feature macro SPEEDUP_EN: the UP window shrinks every fourth hit.
module mole_round_scheduler
  import mole_pkg::*;
#(
  parameter int unsigned GAP_TICKS = 32'd25_000_000,
  parameter int unsigned UP_TICKS  = 32'd50_000_000,
  parameter int unsigned ROUNDS    = 32'd20,
  parameter int unsigned SCORE_W   = 32'd8
`ifdef SPEEDUP_EN
  ,
  parameter int unsigned UP_STEP   = 32'd5_000_000,
  parameter int unsigned UP_MIN    = 32'd10_000_000
`endif
) (
  input logic                   clk,
  input logic                   reset,
  mole_round_scheduler_if.slave bus
);

  localparam int unsigned        RL_W      = $clog2(ROUNDS + 32'd1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_t                state_q, state_d;
  logic [MOLE_IDX_W-1:0] last_mole_q, last_mole_d, pick_s;
  logic [RL_W-1:0]       rounds_left_q, rounds_left_d;
  logic [NUM_MOLES-1:0]  btn_q, rise_s;
  logic [NUM_MOLES-1:0]  mole_on_q, mole_on_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic                  round_done_q, round_done_d;
  logic                  round_hit_q, round_hit_d;
  logic                  game_over_q, game_over_d;
  logic                  busy_q, busy_d;
  logic                  hit_s, tick_zero_s, start_game_s;
  logic                  cnt_load_s, cnt_en_s;
  logic [31:0]           cnt_load_val_s, up_win_s;

  assign rise_s       = bus.hit_btn & ~btn_q;
  // mole_on_q is the one-hot of the active mole, so it doubles as the hit mask.
  assign hit_s        = (state_q == UP) && ((rise_s & mole_on_q) != {NUM_MOLES{1'b0}});
  assign pick_s       = pick_mole(bus.rnd, last_mole_q);
  assign start_game_s = bus.start && ((state_q == IDLE) || (state_q == OVER));

  tick_counter u_tick (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .en       (cnt_en_s),
    .zero     (tick_zero_s)
  );

`ifdef SPEEDUP_EN
  localparam logic [31:0] STEP_FLOOR = 32'(UP_MIN + UP_STEP);

  logic [31:0] up_win_q, up_win_d;
  logic [1:0]  hit_cnt_q, hit_cnt_d;

  // Every fourth hit trims the UP window, clamped at UP_MIN.
  always_comb begin
    up_win_d  = up_win_q;
    hit_cnt_d = hit_cnt_q;
    if (start_game_s) begin
      up_win_d  = 32'(UP_TICKS);
      hit_cnt_d = 2'd0;
    end else if (hit_s) begin
      hit_cnt_d = hit_cnt_q + 2'd1;
      if (hit_cnt_q == 2'd3) begin
        up_win_d = (up_win_q >= STEP_FLOOR) ? (up_win_q - 32'(UP_STEP)) : 32'(UP_MIN);
      end else begin
        up_win_d = up_win_q;
      end
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
  end

  // Speed-up registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_win_q  <= 32'd0;
      hit_cnt_q <= 2'd0;
    end else begin
      up_win_q  <= up_win_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign up_win_s = up_win_q;
`else
  assign up_win_s = 32'(UP_TICKS);
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state; a hit wins over a simultaneous UP timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, OVER: begin
        if (bus.start) state_d = GAP;
        else           state_d = state_q;
      end
      GAP: begin
        if (tick_zero_s) state_d = UP;
        else             state_d = GAP;
      end
      UP: begin
        if (hit_s || tick_zero_s) state_d = RESOLVE;
        else                      state_d = UP;
      end
      RESOLVE: begin
        if (rounds_left_q == RL_W'(1)) state_d = OVER;
        else                           state_d = GAP;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: next values of the registered outputs and datapath, plus counter control.
  always_comb begin
    mole_on_d      = mole_on_q;
    score_d        = score_q;
    round_hit_d    = round_hit_q;
    last_mole_d    = last_mole_q;
    rounds_left_d  = rounds_left_q;
    cnt_load_s     = 1'b0;
    cnt_load_val_s = 32'(GAP_TICKS) - 32'd1;
    cnt_en_s       = (state_q == GAP) || (state_q == UP);
    round_done_d   = (state_q == RESOLVE);
    game_over_d    = (state_d == OVER);
    busy_d         = (state_d == GAP) || (state_d == UP) || (state_d == RESOLVE);
    case (state_q)
      IDLE, OVER: begin
        if (bus.start) begin
          score_d       = {SCORE_W{1'b0}};
          rounds_left_d = RL_W'(ROUNDS);
          cnt_load_s    = 1'b1;
        end else begin
          cnt_load_s    = 1'b0;
        end
      end
      GAP: begin
        if (tick_zero_s) begin
          mole_on_d      = mole_onehot(pick_s);
          last_mole_d    = pick_s;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = up_win_s - 32'd1;
        end else begin
          cnt_load_s     = 1'b0;
        end
      end
      UP: begin
        if (hit_s || tick_zero_s) begin
          mole_on_d   = {NUM_MOLES{1'b0}};
          round_hit_d = hit_s;
          if (hit_s && (score_q != SCORE_MAX)) score_d = score_q + SCORE_W'(1);
          else                                 score_d = score_q;
        end else begin
          round_hit_d = round_hit_q;
        end
      end
      RESOLVE: begin
        rounds_left_d = rounds_left_q - RL_W'(1);
        if (rounds_left_q == RL_W'(1)) cnt_load_s = 1'b0;
        else                           cnt_load_s = 1'b1;
      end
      default: begin
        mole_on_d = {NUM_MOLES{1'b0}};
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mole_on_q     <= {NUM_MOLES{1'b0}};
      score_q       <= {SCORE_W{1'b0}};
      round_done_q  <= 1'b0;
      round_hit_q   <= 1'b0;
      game_over_q   <= 1'b0;
      busy_q        <= 1'b0;
      last_mole_q   <= {MOLE_IDX_W{1'b0}};
      rounds_left_q <= {RL_W{1'b0}};
      btn_q         <= {NUM_MOLES{1'b0}};
    end else begin
      mole_on_q     <= mole_on_d;
      score_q       <= score_d;
      round_done_q  <= round_done_d;
      round_hit_q   <= round_hit_d;
      game_over_q   <= game_over_d;
      busy_q        <= busy_d;
      last_mole_q   <= last_mole_d;
      rounds_left_q <= rounds_left_d;
      btn_q         <= bus.hit_btn;
    end
  end

  assign bus.mole_on    = mole_on_q;
  assign bus.score      = score_q;
  assign bus.round_done = round_done_q;
  assign bus.round_hit  = round_hit_q;
  assign bus.game_over  = game_over_q;
  assign bus.busy       = busy_q;

endmodule
